// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module   : reg_file
// Brief    : General-purpose register file with two combinational read
//            ports, one write port, write-through bypass, a hardwired $0,
//            and a post-reset hardware clear sequence so that the storage
//            does not need a parallel reset.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read_en_1,
    input  logic [ADDR_WIDTH-1:0] read_addr_1,
    output logic [DATA_WIDTH-1:0] read_data_1,
    input  logic                  read_en_2,
    input  logic [ADDR_WIDTH-1:0] read_addr_2,
    output logic [DATA_WIDTH-1:0] read_data_2,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  init_busy,
    input  logic [ADDR_WIDTH-1:0] debug_addr,
    output logic [DATA_WIDTH-1:0] debug_data
);

    localparam int                    REG_NUM  = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(REG_NUM - 1);
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = '0;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_idx_q, clr_idx_d;
    logic [DATA_WIDTH-1:0]   mem_q [REG_NUM];

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    ready;

    assign ready = rst && (state_q == READY);

    // State and clear counter; reset restarts the clear at entry 1 ($0 is hardwired).
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= INIT;
            clr_idx_q <= ADDR_WIDTH'(1);
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Next state plus the single storage write port, shared by clear and WB writes.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        mem_we    = 1'b0;
        mem_waddr = write_addr;
        mem_wdata = write_data;
        case (state_q)
            INIT: begin
                mem_we    = 1'b1;
                mem_waddr = clr_idx_q;
                mem_wdata = '0;
                if (clr_idx_q == LAST_IDX) begin
                    // Counter holds at the last entry; it is unused once READY.
                    state_d = READY;
                end else begin
                    clr_idx_d = clr_idx_q + ADDR_WIDTH'(1);
                end
            end
            READY: begin
                mem_we = write_en && (write_addr != ZERO_IDX);
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // Storage array without reset so it can map onto RAM; reset edges never write it.
    always_ff @(posedge clk) begin
        if (rst && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Read port 1: gated to zero when not ready/disabled/$0, bypasses a same-cycle write.
    always_comb begin
        read_data_1 = '0;
        if (ready && read_en_1 && (read_addr_1 != ZERO_IDX)) begin
            if (write_en && (write_addr == read_addr_1)) begin
                read_data_1 = write_data;
            end else begin
                read_data_1 = mem_q[read_addr_1];
            end
        end
    end

    // Read port 2: identical behaviour to port 1.
    always_comb begin
        read_data_2 = '0;
        if (ready && read_en_2 && (read_addr_2 != ZERO_IDX)) begin
            if (write_en && (write_addr == read_addr_2)) begin
                read_data_2 = write_data;
            end else begin
                read_data_2 = mem_q[read_addr_2];
            end
        end
    end

    // Debug peek shows raw storage with no bypass; entry 0 is never stored so it is forced to 0.
    always_comb begin
        debug_data = '0;
        if (debug_addr != ZERO_IDX) begin
            debug_data = mem_q[debug_addr];
        end
    end

    assign init_busy = !ready;

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file
// Brief    : Self-checking bench for reg_file: directed steps followed by a
//            randomized phase, all compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        re1, re2, we;
    logic [4:0]  ra1, ra2, wa, dbg_a;
    logic [31:0] wd;
    logic [31:0] rd1, rd2, dbg_d;
    logic        busy;

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural model: register contents, which entries hold a defined value,
    // and how many clear edges remain before the file is usable.
    logic [31:0] model [32];
    bit          known [32];
    int          clr_left = 31;
    int          next_clr = 1;

    reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .read_en_1  (re1),
        .read_addr_1(ra1),
        .read_data_1(rd1),
        .read_en_2  (re2),
        .read_addr_2(ra2),
        .read_data_2(rd2),
        .write_en   (we),
        .write_addr (wa),
        .write_data (wd),
        .init_busy  (busy),
        .debug_addr (dbg_a),
        .debug_data (dbg_d)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic r, input logic e1, input logic [4:0] a1,
                          input logic e2, input logic [4:0] a2,
                          input logic w, input logic [4:0] wad, input logic [31:0] wdat);
        rst = r; re1 = e1; ra1 = a1; re2 = e2; ra2 = a2; we = w; wa = wad; wd = wdat;
        #1;
    endtask

    function automatic logic [31:0] exp_rd(input logic en, input logic [4:0] a);
        if (!rst || clr_left > 0 || !en || a == 5'd0) return 32'd0;
        if (we && wa == a) return wd;
        return model[a];
    endfunction

    task automatic check_all(input string tag);
        check({tag, "_rd1"}, rd1, exp_rd(re1, ra1));
        check({tag, "_rd2"}, rd2, exp_rd(re2, ra2));
        check({tag, "_busy"}, {31'd0, busy}, {31'd0, (!rst || clr_left > 0)});
        if (known[dbg_a]) check({tag, "_dbg"}, dbg_d, model[dbg_a]);
    endtask

    // Advance one clock edge, applying the architectural effect of the current inputs.
    task automatic tick();
        if (!rst) begin
            clr_left = 31;
            next_clr = 1;
        end else if (clr_left > 0) begin
            model[next_clr] = 32'd0;
            known[next_clr] = 1'b1;
            next_clr++;
            clr_left--;
        end else if (we && wa != 5'd0) begin
            model[wa] = wd;
            known[wa] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic count_clear(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (busy === 1'b1 && cnt < 100);
    endtask

    task automatic check_all_zero(input string tag);
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        for (int a = 0; a < 32; a++) begin
            dbg_a = 5'(a);
            #1;
            check(tag, dbg_d, 32'd0);
            tick();
        end
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < 32; i++) begin
            model[i] = 32'd0;
            known[i] = (i == 0);
        end
        dbg_a = 5'd0;
        set_in(0, 1, 5'd1, 1, 5'd2, 0, 0, 0);
        @(posedge clk);
        #1;

        // Reset held three cycles: busy high, reads gated to zero.
        for (int i = 0; i < 3; i++) tick();
        check_all("reset");

        // Release and measure clear latency.
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        count_clear(cnt);
        check("clr_cycles", cnt, 32'd31);
        check_all_zero("clr_zero");

        // Preload with DEADBEEF, then reset and clear again, writing r9 throughout INIT.
        for (int a = 1; a < 32; a++) begin
            set_in(1, 0, 0, 0, 0, 1, 5'(a), 32'hDEADBEEF);
            tick();
        end
        dbg_a = 5'd12;
        #1;
        check("preload", dbg_d, 32'hDEADBEEF);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick();
        set_in(1, 1, 5'd9, 1, 5'd9, 1, 5'd9, 32'h00000055);
        check_all("init_write");
        count_clear(cnt);
        check("clr_cycles2", cnt, 32'd31);
        check_all_zero("reclr_zero");

        // Basic write, then read on both ports next cycle.
        set_in(1, 0, 0, 0, 0, 1, 5'd5, 32'h12345678);
        tick();
        set_in(1, 1, 5'd5, 1, 5'd5, 0, 0, 0);
        check_all("basic");
        check("basic_rd1_lit", rd1, 32'h12345678);

        // Same-cycle bypass on both ports; storage unchanged until the edge.
        dbg_a = 5'd7;
        set_in(1, 1, 5'd7, 1, 5'd7, 1, 5'd7, 32'hA5A5A5A5);
        check("byp_rd1", rd1, 32'hA5A5A5A5);
        check("byp_rd2", rd2, 32'hA5A5A5A5);
        check("byp_dbg_old", dbg_d, 32'd0);
        tick();
        check("byp_dbg_new", dbg_d, 32'hA5A5A5A5);

        // Zero register ignores writes and bypass.
        dbg_a = 5'd0;
        set_in(1, 1, 5'd0, 1, 5'd0, 1, 5'd0, 32'hFFFFFFFF);
        check_all("r0");
        tick();
        check("r0_dbg", dbg_d, 32'd0);

        // Read enable gating.
        set_in(1, 0, 0, 0, 0, 1, 5'd3, 32'h00000042);
        tick();
        set_in(1, 0, 5'd3, 1, 5'd3, 0, 0, 0);
        check("ren_off", rd1, 32'd0);
        check("ren_on", rd2, 32'h00000042);

        // Randomized traffic with occasional resets, checked every cycle.
        for (int i = 0; i < 400; i++) begin
            dbg_a = 5'($urandom_range(0, 31));
            set_in($urandom_range(0, 59) != 0,
                   1'($urandom), 5'($urandom_range(0, 7)),
                   1'($urandom), 5'($urandom_range(0, 7)),
                   1'($urandom), 5'($urandom_range(0, 7)), $urandom);
            check_all("rand");
            tick();
        end

        // Mid-clear reset restarts a fresh 31-cycle clear.
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) tick();
        check("mid_busy", {31'd0, busy}, 32'd1);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        count_clear(cnt);
        check("mid_clr_cycles", cnt, 32'd31);
        check_all_zero("mid_zero");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_file.md
# reg_file

General-purpose register file for the five-stage CPU. It is the responder for the ID stage's two read-request ports (`reg_read_en_*`/`reg_addr_*` → `reg_data_*`) and the sink for the WB stage's single write port. It owns the architectural GPR state, hardwires `$0`, and forwards same-cycle writes to the readers. After every reset it runs a hardware clear sequence so the storage can map to RAM without a parallel reset.

## Interface
Parameters:
- `DATA_WIDTH`, 32, register width.
- `ADDR_WIDTH`, 5, register address width; `REG_NUM = 2**ADDR_WIDTH`.

Ports:
- `clk`  in  1  the only clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-low: sampled only on the `clk` rising edge, and it takes effect when 0.
- `read_en_1`  in  1  read port 1 enable (from ID `reg_read_en_1`).
- `read_addr_1`  in  ADDR_WIDTH  read port 1 address.
- `read_data_1`  out  DATA_WIDTH  read port 1 data, combinational.
- `read_en_2`, `read_addr_2`, `read_data_2`: port 2, identical to port 1.
- `write_en`  in  1  write enable (from WB).
- `write_addr`  in  ADDR_WIDTH  write address.
- `write_data`  in  DATA_WIDTH  write data.
- `init_busy`  out  1  high while the clear sequence runs; the pipeline holds the PC while this is high.
- `debug_addr`  in  ADDR_WIDTH  debug/bench peek address.
- `debug_data`  out  DATA_WIDTH  raw stored value at `debug_addr`, with no bypass.

## Operation
- State machine states: `INIT` and `READY`. A clear counter `clr_idx` is ADDR_WIDTH bits wide.
- Reset (`rst`=0 at an edge):
  - Next state is `INIT` and `clr_idx` becomes 1.
  - Storage is not otherwise touched.
- `INIT`:
  - Each edge with `rst`=1 writes 0 to entry `clr_idx` and increments `clr_idx`.
  - At `clr_idx == REG_NUM-1`, the state becomes `READY` after that entry is written.
  - `write_en` is ignored; no storage writes occur except the clear writes.
- `READY`:
  - At an edge with `write_en`=1 and `write_addr`≠0, `mem[write_addr]` is set to `write_data`.
  - A write to address 0 is dropped.
- Read port n (combinational), in priority order:
  - `rst`=0, state `INIT`, `read_en_n`=0, or `read_addr_n`=0 → 0.
  - Else, if `write_en`=1 and `write_addr`==`read_addr_n` → `write_data` (write-through bypass).
  - Else → `mem[read_addr_n]`.
- Both ports may read the same address. Both bypass independently.
- `debug_data` = `mem[debug_addr]`. Entry 0 always reads 0. During `INIT` it returns the stored value (0 once cleared).
- `init_busy` = 1 when `rst`=0 or state is `INIT`; 0 otherwise.

## Timing
- Reset values:
  - `init_busy`=1.
  - `read_data_1`=`read_data_2`=0 while `rst`=0.
  - `debug_data` reflects storage.
- Clear latency: after the edge that samples `rst`=0 and then releases reset, `init_busy` stays high for exactly `REG_NUM-1` (31) edges. It drops after the edge that clears entry 31.
- Write latency: the value is visible through the bypass in the same cycle, and from storage after the edge.
- A reset asserted mid-clear restarts the sequence at `clr_idx`=1.
- A reset asserted in `READY` re-enters `INIT`; the storage contents are re-cleared over the next 31 cycles.
- A write that coincides with the `INIT`→`READY` edge is dropped. The first accepted write is on the first edge where `init_busy`=0 was visible beforehand.
- `clr_idx` never wraps: it stops being used once the state is `READY`.

## Test plan
- Reset and clear:
  - Stimulus: hold `rst`=0 for 3 cycles, release, then count cycles until `init_busy` falls.
  - Required: exactly 31 cycles.
  - Required: `debug_data` = 0 for every address 0..31 afterwards, including after pre-loading with 0xDEADBEEF before reset.
- Basic write/read:
  - Stimulus: write 0x12345678 to r5; next cycle read port 1 r5 and port 2 r5.
  - Required: both ports return 0x12345678.
- Bypass:
  - Stimulus: in the same cycle, write 0xA5A5A5A5 to r7 and read r7 on both ports.
  - Required: both ports return 0xA5A5A5A5.
  - Required: `debug_data`(r7) shows the old value until the edge.
- Zero register:
  - Stimulus: write 0xFFFFFFFF to r0 while reading r0 on both ports with bypass conditions met.
  - Required: reads return 0, and `debug_data`(0) = 0 after the edge.
- Read enable and INIT gating:
  - Stimulus: r3 = 0x00000042 and `read_en_1`=0.
  - Required: `read_data_1` = 0.
  - Stimulus: write during `INIT`.
  - Required: the write is ignored, and the entry is 0 after `READY`.
- Mid-clear reset:
  - Stimulus: assert `rst`=0 at clear cycle 10, then release.
  - Required: `init_busy` is high for a fresh 31 cycles, and all entries read 0 afterwards.
